// File: rtl/pipe_stage_fifo_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage: the upstream (in_*) and downstream (out_*) sides.
// master = surrounding pipeline (producer + consumer), slave = the stage itself.
interface pipe_stage_fifo_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_fifo.sv
// Elastic DEPTH-entry pipeline stage register with flush; 1-cycle latency, no comb in->out path.
// Backpressure: in_ready drops when full (or when full without a same-cycle dequeue if REG_READY=0), and during flush/reset.
module pipe_stage_fifo #(
    parameter int W         = 64,
    parameter int DEPTH     = 2,
    parameter int REG_READY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    pipe_stage_fifo_if.slave           bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          enq;
    logic          deq;
    logic          pass_when_full;

    assign pass_when_full = (REG_READY == 0) && bus.out_ready;
    assign full           = (count == CW'(DEPTH));
    assign bus.in_ready   = !reset && !flush && (!full || pass_when_full);
    assign bus.out_valid  = (count != '0);
    assign bus.out_data   = bus.out_valid ? mem[rd_ptr] : '0;

    assign enq = bus.in_valid && bus.in_ready;
    assign deq = bus.out_valid && bus.out_ready;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is never cleared; the output mux masks stale entries instead.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));
    a_head_stable : assert property (@(posedge clk) disable iff (reset)
        (bus.out_valid && !bus.out_ready && !flush) |=> $stable(bus.out_data));
endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed and randomised checks of pipe_stage_fifo in three configurations (D2/RR1, D2/RR0, D3/RR1).
module tb_pipe_stage_fifo;
    logic clk = 1'b0;
    logic reset;
    logic f2, f2r, f3;
    logic [1:0] c2, c2r, c3;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_fifo_if #(.W(8)) b2 ();
    pipe_stage_fifo_if #(.W(8)) b2r ();
    pipe_stage_fifo_if #(.W(8)) b3 ();

    pipe_stage_fifo #(.W(8), .DEPTH(2), .REG_READY(1)) u_d2 (
        .clk(clk), .reset(reset), .flush(f2), .bus(b2.slave), .count(c2));
    pipe_stage_fifo #(.W(8), .DEPTH(2), .REG_READY(0)) u_d2r (
        .clk(clk), .reset(reset), .flush(f2r), .bus(b2r.slave), .count(c2r));
    pipe_stage_fifo #(.W(8), .DEPTH(3), .REG_READY(1)) u_d3 (
        .clk(clk), .reset(reset), .flush(f3), .bus(b3.slave), .count(c3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        f2 = 1'b0; f2r = 1'b0; f3 = 1'b0;
        b2.in_valid = 1'b1;  b2.in_data = 8'hEE; b2.out_ready = 1'b0;
        b2r.in_valid = 1'b0; b2r.in_data = 8'h00; b2r.out_ready = 1'b0;
        b3.in_valid = 1'b0;  b3.in_data = 8'h00; b3.out_ready = 1'b0;
        #1;
        checks++;
        if (b2.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_low got=%b exp=0", b2.in_ready);
        end
        tick();
        tick();
        reset = 1'b0;
        b2.in_valid = 1'b0;
        #1;
        checks++;
        if ({b2.in_ready, b2r.in_ready, b3.in_ready} !== 3'b111) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=111", {b2.in_ready, b2r.in_ready, b3.in_ready});
        end
        checks++;
        if ({c2, c2r, c3} !== 6'd0) begin
            errors++; $display("FAIL reset_count got=%0d/%0d/%0d exp=0/0/0", c2, c2r, c3);
        end
        checks++;
        if ({b2.out_valid, b2r.out_valid, b3.out_valid} !== 3'b000 ||
            {b2.out_data, b2r.out_data, b3.out_data} !== 24'h0) begin
            errors++; $display("FAIL reset_out got=%b data=%h exp=000 data=0",
                {b2.out_valid, b2r.out_valid, b3.out_valid}, {b2.out_data, b2r.out_data, b3.out_data});
        end
    endtask

    task automatic test_stream();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        b2.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b2.in_valid = 1'b1;
            b2.in_data  = vals[i];
            #1;
            checks++;
            if (b2.in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, b2.in_ready);
            end
            tick();
            checks++;
            if (b2.out_valid !== 1'b1 || b2.out_data !== vals[i] || c2 !== 2'd1) begin
                errors++; $display("FAIL stream_out[%0d] got v=%b d=%h c=%0d exp v=1 d=%h c=1",
                    i, b2.out_valid, b2.out_data, c2, vals[i]);
            end
        end
        b2.in_valid = 1'b0;
        tick();
        checks++;
        if (c2 !== 2'd0 || b2.out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain got c=%0d v=%b exp c=0 v=0", c2, b2.out_valid);
        end
    endtask

    task automatic test_stall();
        b2.out_ready = 1'b0;
        b2.in_valid  = 1'b1;
        b2.in_data   = 8'hA1;
        tick();
        b2.in_data = 8'hA2;
        tick();
        b2.in_data = 8'hA3;
        #1;
        checks++;
        if (c2 !== 2'd2 || b2.in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_full got c=%0d rdy=%b exp c=2 rdy=0", c2, b2.in_ready);
        end
        tick();
        checks++;
        if (c2 !== 2'd2 || b2.out_data !== 8'hA1) begin
            errors++; $display("FAIL stall_hold got c=%0d d=%h exp c=2 d=a1", c2, b2.out_data);
        end
        b2.out_ready = 1'b1;
        #1;
        checks++;
        if (b2.in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_regready_full got=%b exp=0", b2.in_ready);
        end
        tick();
        checks++;
        if (c2 !== 2'd1 || b2.out_data !== 8'hA2 || b2.in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_second got c=%0d d=%h rdy=%b exp c=1 d=a2 rdy=1",
                c2, b2.out_data, b2.in_ready);
        end
        tick();
        checks++;
        if (c2 !== 2'd1 || b2.out_data !== 8'hA3) begin
            errors++; $display("FAIL stall_third got c=%0d d=%h exp c=1 d=a3", c2, b2.out_data);
        end
        b2.in_valid = 1'b0;
        tick();
        checks++;
        if (c2 !== 2'd0 || b2.out_valid !== 1'b0 || b2.out_data !== 8'h00) begin
            errors++; $display("FAIL stall_empty got c=%0d v=%b d=%h exp c=0 v=0 d=00",
                c2, b2.out_valid, b2.out_data);
        end
        // Dequeue request on an empty stage must not underflow.
        tick();
        checks++;
        if (c2 !== 2'd0) begin
            errors++; $display("FAIL empty_underflow got c=%0d exp c=0", c2);
        end
        b2.out_ready = 1'b0;
    endtask

    task automatic test_full_passthru();
        b2r.out_ready = 1'b0;
        b2r.in_valid  = 1'b1;
        b2r.in_data   = 8'h51;
        tick();
        b2r.in_data = 8'h52;
        tick();
        b2r.in_data = 8'h55;
        #1;
        checks++;
        if (c2r !== 2'd2 || b2r.in_ready !== 1'b0) begin
            errors++; $display("FAIL rr0_full got c=%0d rdy=%b exp c=2 rdy=0", c2r, b2r.in_ready);
        end
        b2r.out_ready = 1'b1;
        #1;
        checks++;
        if (b2r.in_ready !== 1'b1) begin
            errors++; $display("FAIL rr0_pass_ready got=%b exp=1", b2r.in_ready);
        end
        tick();
        b2r.in_valid = 1'b0;
        checks++;
        if (c2r !== 2'd2 || b2r.out_data !== 8'h52) begin
            errors++; $display("FAIL rr0_after_pass got c=%0d d=%h exp c=2 d=52", c2r, b2r.out_data);
        end
        tick();
        checks++;
        if (c2r !== 2'd1 || b2r.out_data !== 8'h55) begin
            errors++; $display("FAIL rr0_new_last got c=%0d d=%h exp c=1 d=55", c2r, b2r.out_data);
        end
        tick();
        checks++;
        if (c2r !== 2'd0 || b2r.out_valid !== 1'b0) begin
            errors++; $display("FAIL rr0_drain got c=%0d v=%b exp c=0 v=0", c2r, b2r.out_valid);
        end
        b2r.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        b2.out_ready = 1'b0;
        b2.in_valid  = 1'b1;
        b2.in_data   = 8'h61;
        tick();
        b2.in_data = 8'h62;
        tick();
        b2.in_data = 8'h77;
        f2 = 1'b1;
        #1;
        checks++;
        if (b2.in_ready !== 1'b0 || b2.out_valid !== 1'b1 || b2.out_data !== 8'h61) begin
            errors++; $display("FAIL flush_cycle got rdy=%b v=%b d=%h exp rdy=0 v=1 d=61",
                b2.in_ready, b2.out_valid, b2.out_data);
        end
        tick();
        checks++;
        if (c2 !== 2'd0 || b2.out_valid !== 1'b0 || b2.out_data !== 8'h00) begin
            errors++; $display("FAIL flush_after got c=%0d v=%b d=%h exp c=0 v=0 d=00",
                c2, b2.out_valid, b2.out_data);
        end
        tick();
        checks++;
        if (c2 !== 2'd0 || b2.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_held got c=%0d v=%b exp c=0 v=0", c2, b2.out_valid);
        end
        f2 = 1'b0;
        b2.in_valid = 1'b0;
        b2.out_ready = 1'b1;
        tick();
        checks++;
        if (b2.out_valid !== 1'b0 || c2 !== 2'd0) begin
            errors++; $display("FAIL flush_no_leak got v=%b d=%h exp v=0", b2.out_valid, b2.out_data);
        end
        b2.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        b2.out_ready = 1'b0;
        b2.in_valid  = 1'b1;
        b2.in_data   = 8'h81;
        tick();
        b2.in_data = 8'h82;
        reset = 1'b1;
        #1;
        checks++;
        if (b2.in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_in_ready got=%b exp=0", b2.in_ready);
        end
        tick();
        reset = 1'b0;
        b2.in_valid = 1'b0;
        #1;
        checks++;
        if (c2 !== 2'd0 || b2.out_valid !== 1'b0 || b2.out_data !== 8'h00) begin
            errors++; $display("FAIL rstmid_state got c=%0d v=%b d=%h exp c=0 v=0 d=00",
                c2, b2.out_valid, b2.out_data);
        end
        b2.in_valid = 1'b1;
        b2.in_data  = 8'h99;
        tick();
        b2.in_valid = 1'b0;
        checks++;
        if (b2.out_valid !== 1'b1 || b2.out_data !== 8'h99 || c2 !== 2'd1) begin
            errors++; $display("FAIL rstmid_first got v=%b d=%h c=%0d exp v=1 d=99 c=1",
                b2.out_valid, b2.out_data, c2);
        end
        b2.out_ready = 1'b1;
        tick();
        b2.out_ready = 1'b0;
    endtask

    task automatic test_random_d3();
        logic [7:0] q [$];
        logic       exp_rdy;
        logic       exp_vld;
        logic [7:0] exp_dat;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            b3.in_valid  = 1'($urandom_range(0, 1));
            b3.in_data   = 8'($urandom_range(0, 255));
            b3.out_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            if (cyc % 200 < 100) b3.out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = (q.size() < 3);
            exp_vld = (q.size() != 0);
            exp_dat = exp_vld ? q[0] : 8'h00;
            checks++;
            if (b3.in_ready !== exp_rdy || b3.out_valid !== exp_vld) begin
                errors++; $display("FAIL rand_hs[%0d] got rdy=%b v=%b exp rdy=%b v=%b",
                    cyc, b3.in_ready, b3.out_valid, exp_rdy, exp_vld);
            end
            checks++;
            if (b3.out_data !== exp_dat) begin
                errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", cyc, b3.out_data, exp_dat);
            end
            checks++;
            if (c3 !== 2'(q.size())) begin
                errors++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", cyc, c3, q.size());
            end
            if (exp_vld && b3.out_ready) void'(q.pop_front());
            if (b3.in_valid && exp_rdy) q.push_back(b3.in_data);
            tick();
        end
        b3.in_valid  = 1'b0;
        b3.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_full_passthru();
        test_flush();
        test_reset_mid();
        test_random_d3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
